// File: rtl/vga_timing_pkg.sv
// Shared timing defaults and phase encodings for the VGA timing generator.
package vga_timing_pkg;

    localparam int unsigned CNT_W         = 10;
    localparam int unsigned CE_DIV_DEF    = 2;
    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    localparam int unsigned H_TOTAL_DEF =
        H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL_DEF =
        V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef enum logic [1:0] {HAct, HFp, HSync, HBp} h_phase_t;
    typedef enum logic [1:0] {VAct, VFp, VSync, VBp} v_phase_t;

endpackage

// File: rtl/mod_counter.sv
// Wrap-at-Max counter with enable; exposes its next-state value and a wrap strobe.
module mod_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned Width = CNT_W,
    parameter int unsigned Max   = H_TOTAL_DEF - 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o,
    output logic [Width-1:0] cnt_d_o,
    output logic             wrap_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        wrap_o = !rst_i && en_i && (cnt_q == Width'(Max));
        cnt_d  = cnt_q;
        if (rst_i || wrap_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign cnt_d_o = cnt_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: prescaled pixel counters, phase FSMs and registered sync/blank strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CE_DIV    = CE_DIV_DEF,
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    output logic             pixel_ce,
    output logic [CNT_W-1:0] DrawX,
    output logic [CNT_W-1:0] DrawY,
    output logic             hs_n,
    output logic             vs_n,
    output logic             blank_n,
    output logic             frame_tick
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_0 = H_VISIBLE + H_FRONT;
    localparam int unsigned H_BACK_0 = H_SYNC_0 + H_SYNC;
    localparam int unsigned V_SYNC_0 = V_VISIBLE + V_FRONT;
    localparam int unsigned V_BACK_0 = V_SYNC_0 + V_SYNC;

    logic [1:0]       ce_cnt, ce_cnt_d;
    logic             ce_wrap, h_wrap, v_wrap;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    h_phase_t         h_state_q, h_state_d;
    v_phase_t         v_state_q, v_state_d;
    logic             hs_n_d, vs_n_d, blank_n_d, frame_tick_d;
    logic             hs_n_q, vs_n_q, blank_n_q, frame_tick_q;

    mod_counter #(.Width(2), .Max(CE_DIV - 1)) u_ce_cnt (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .en_i   (1'b1),
        .cnt_o  (ce_cnt),
        .cnt_d_o(ce_cnt_d),
        .wrap_o (ce_wrap)
    );

    mod_counter #(.Width(CNT_W), .Max(H_TOTAL - 1)) u_h_cnt (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .en_i   (ce_wrap),
        .cnt_o  (x_q),
        .cnt_d_o(x_d),
        .wrap_o (h_wrap)
    );

    mod_counter #(.Width(CNT_W), .Max(V_TOTAL - 1)) u_v_cnt (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .en_i   (h_wrap),
        .cnt_o  (y_q),
        .cnt_d_o(y_d),
        .wrap_o (v_wrap)
    );

    logic unused_sig;
    assign unused_sig = ^{ce_cnt, ce_cnt_d, v_wrap};

    // Phases are decoded from the next counter values so the registered strobes line up
    // with the coordinates presented in the same cycle.
    always_comb begin
        h_state_d = h_state_q;
        v_state_d = v_state_q;
        if (Reset) begin
            h_state_d = HAct;
            v_state_d = VAct;
        end else begin
            if (ce_wrap) begin
                if (x_d == '0)                         h_state_d = HAct;
                else if (x_d == CNT_W'(H_VISIBLE))     h_state_d = HFp;
                else if (x_d == CNT_W'(H_SYNC_0))      h_state_d = HSync;
                else if (x_d == CNT_W'(H_BACK_0))      h_state_d = HBp;
            end
            if (h_wrap) begin
                if (y_d == '0)                         v_state_d = VAct;
                else if (y_d == CNT_W'(V_VISIBLE))     v_state_d = VFp;
                else if (y_d == CNT_W'(V_SYNC_0))      v_state_d = VSync;
                else if (y_d == CNT_W'(V_BACK_0))      v_state_d = VBp;
            end
        end
        hs_n_d       = (h_state_d != HSync);
        vs_n_d       = (v_state_d != VSync);
        blank_n_d    = (h_state_d == HAct) && (v_state_d == VAct);
        frame_tick_d = h_wrap && (y_d == CNT_W'(V_VISIBLE));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            h_state_q    <= HAct;
            v_state_q    <= VAct;
            hs_n_q       <= 1'b1;
            vs_n_q       <= 1'b1;
            blank_n_q    <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            h_state_q    <= h_state_d;
            v_state_q    <= v_state_d;
            hs_n_q       <= hs_n_d;
            vs_n_q       <= vs_n_d;
            blank_n_q    <= blank_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign pixel_ce   = ce_wrap;
    assign DrawX      = x_q;
    assign DrawY      = y_q;
    assign hs_n       = hs_n_q;
    assign vs_n       = vs_n_q;
    assign blank_n    = blank_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size line checks plus shrunken-raster frame checks at CE_DIV 2 and 1.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_def, rst_sm;
    logic       d_pce, d_hs, d_vs, d_bl, d_ft;
    logic [9:0] d_x, d_y;
    logic       s_pce, s_hs, s_vs, s_bl, s_ft;
    logic [9:0] s_x, s_y;
    logic       c_pce, c_hs, c_vs, c_bl, c_ft;
    logic [9:0] c_x, c_y;

    vga_timing_gen u_def (
        .Clk(clk), .Reset(rst_def), .pixel_ce(d_pce), .DrawX(d_x), .DrawY(d_y),
        .hs_n(d_hs), .vs_n(d_vs), .blank_n(d_bl), .frame_tick(d_ft)
    );

    // Small raster: 17 x 13 (H 10/2/3/2, V 6/2/2/3)
    vga_timing_gen #(
        .CE_DIV(2), .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_sm (
        .Clk(clk), .Reset(rst_sm), .pixel_ce(s_pce), .DrawX(s_x), .DrawY(s_y),
        .hs_n(s_hs), .vs_n(s_vs), .blank_n(s_bl), .frame_tick(s_ft)
    );

    vga_timing_gen #(
        .CE_DIV(1), .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_c1 (
        .Clk(clk), .Reset(rst_sm), .pixel_ce(c_pce), .DrawX(c_x), .DrawY(c_y),
        .hs_n(c_hs), .vs_n(c_vs), .blank_n(c_bl), .frame_tick(c_ft)
    );

    typedef struct {
        int       cyc;
        int       x;
        int       y;
        bit [4:0] flags; // {pce, hs_n, vs_n, blank_n, frame_tick}
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl[NVEC];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input int cyc, input int x, input int y, input bit [4:0] f);
        vec_t v;
        v.cyc = cyc; v.x = x; v.y = y; v.flags = f;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int s_t[$];
        int c_t[$];
        int s_vs_low, c_pce_low;
        int hs_low, hs_out, first_bl_x, wrap_seen, wrap_y, prev_x;
        bit [4:0] act_f;

        tbl[0]  = mk(1,   0,  0, 5'b01110);
        tbl[1]  = mk(2,   0,  0, 5'b11110);
        tbl[2]  = mk(3,   1,  0, 5'b01110);
        tbl[3]  = mk(21,  10, 0, 5'b01100);
        tbl[4]  = mk(25,  12, 0, 5'b00100);
        tbl[5]  = mk(30,  14, 0, 5'b10100);
        tbl[6]  = mk(31,  15, 0, 5'b01100);
        tbl[7]  = mk(34,  16, 0, 5'b11100);
        tbl[8]  = mk(35,  0,  1, 5'b01110);
        tbl[9]  = mk(205, 0,  6, 5'b01101);
        tbl[10] = mk(206, 0,  6, 5'b11100);
        tbl[11] = mk(273, 0,  8, 5'b01000);
        tbl[12] = mk(339, 16, 9, 5'b01000);
        tbl[13] = mk(341, 0, 10, 5'b01100);
        tbl[14] = mk(442, 16, 12, 5'b11100);
        tbl[15] = mk(443, 0,  0, 5'b01110);
        tbl[16] = mk(647, 0,  6, 5'b01101);

        rst_def = 1'b1;
        rst_sm  = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset s_xy", int'({s_x, s_y}), 0);
        chk("reset s_flags", int'({s_pce, s_hs, s_vs, s_bl, s_ft}), 5'b01110);
        chk("reset c1 pixel_ce", int'(c_pce), 0);
        chk("reset def flags", int'({d_pce, d_hs, d_vs, d_bl, d_ft}), 5'b01110);

        // Shrunken-raster frames
        @(posedge clk);
        #1 rst_sm = 1'b0;
        s_vs_low  = 0;
        c_pce_low = 0;
        for (int k = 1; k <= 700; k++) begin
            @(negedge clk);
            for (int v = 0; v < NVEC; v++) begin
                if (tbl[v].cyc == k) begin
                    act_f = {s_pce, s_hs, s_vs, s_bl, s_ft};
                    checks++;
                    if (int'(s_x) != tbl[v].x || int'(s_y) != tbl[v].y || act_f != tbl[v].flags)
                    begin
                        errors++;
                        $display("FAIL vec cyc%0d: got (%0d,%0d) flags %b, expected (%0d,%0d) %b",
                                 k, s_x, s_y, act_f, tbl[v].x, tbl[v].y, tbl[v].flags);
                    end
                end
            end
            if (s_ft) s_t.push_back(k);
            if (c_ft) c_t.push_back(k);
            if (!s_vs && k <= 442) s_vs_low++;
            if (!c_pce) c_pce_low++;
        end
        chk("s frame_tick count", s_t.size(), 2);
        if (s_t.size() >= 2) chk("s frame period", s_t[1] - s_t[0], 442);
        chk("s vs_n low cycles", s_vs_low, 68);
        chk("c1 pixel_ce low cycles", c_pce_low, 0);
        chk("c1 frame_tick count", c_t.size(), 3);
        if (c_t.size() >= 2) chk("c1 frame period", c_t[1] - c_t[0], 221);

        // Full-size first line
        @(posedge clk);
        #1 rst_def = 1'b0;
        hs_low = 0; hs_out = 0; first_bl_x = -1; wrap_seen = 0; wrap_y = -1; prev_x = 0;
        for (int k = 1; k <= 1610; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("def cyc1 DrawX", int'(d_x), 0);
                chk("def cyc1 pixel_ce", int'(d_pce), 0);
            end
            if (k == 2) chk("def cyc2 pixel_ce", int'(d_pce), 1);
            if (k == 3) chk("def cyc3 DrawX", int'(d_x), 1);
            if (d_y == 10'd0) begin
                if (!d_hs) begin
                    hs_low++;
                    if (d_x < 10'd656 || d_x > 10'd751) hs_out++;
                end
                if (!d_bl && first_bl_x < 0) first_bl_x = int'(d_x);
            end
            if (prev_x == 799 && d_x == 10'd0) begin
                wrap_seen++;
                wrap_y = int'(d_y);
            end
            prev_x = int'(d_x);
        end
        chk("def hs_n low cycles", hs_low, 192);
        chk("def hs_n low outside sync", hs_out, 0);
        chk("def first blank x", first_bl_x, 640);
        chk("def line wraps", wrap_seen, 1);
        chk("def wrap DrawY", wrap_y, 1);

        // One-cycle reset in the middle of horizontal sync
        for (int n = 0; n < 3000 && !(d_x == 10'd700 && d_y == 10'd1); n++) @(negedge clk);
        chk("def reached (700,1)", int'(d_x == 10'd700 && d_y == 10'd1), 1);
        chk("def hs_n at 700", int'(d_hs), 0);
        rst_def = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset xy", int'({d_x, d_y}), 0);
        chk("midreset flags", int'({d_hs, d_vs, d_bl, d_ft}), 4'b1110);
        rst_def = 1'b0;
        repeat (3) @(negedge clk);
        chk("resume DrawX", int'(d_x), 1);
        chk("resume hs_n", int'(d_hs), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
